// File: rtl/c1_share_arbiter.sv
// Round-robin arbiter that time-shares one C1 logic-cell evaluator among NREQ requesters.
// Each grant latches one configuration, evaluates it, and returns a registered, id-tagged result.
//
// state  | meaning
// IDLE   | waiting for any req; picks round-robin winner and latches its cfg
// EVAL   | gnt high; shared cell evaluates the latched cfg
// RESP   | res_valid high; result and id presented
module c1_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   cfg_flat,
    output logic [NREQ-1:0]     gnt,
    output logic                res_valid,
    output logic [IDW-1:0]      res_id,
    output logic                res_out,
    output logic                busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     state;
    logic [7:0]     cfg_r;
    logic [IDW-1:0] id_r;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;

    // cfg bit order {s1,s0,sb,b1,b0,sa,a1,a0}
    function automatic logic c1_eval(input logic [7:0] c);
        return (c[7] | c[6]) ? (c[5] ? c[4] : c[3]) : (c[2] ? c[1] : c[0]);
    endfunction

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (i == IDW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Search starts at ptr and wraps modulo NREQ; first requester found wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = next_idx(idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_out   <= 1'b0;
            res_id    <= '0;
            cfg_r     <= '0;
            id_r      <= '0;
            ptr       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        cfg_r <= cfg_flat[8*win +: 8];
                        id_r  <= win;
                        gnt   <= NREQ'(1) << win;
                        ptr   <= next_idx(win);
                        state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    res_out   <= c1_eval(cfg_r);
                    res_id    <= id_r;
                    res_valid <= 1'b1;
                    gnt       <= '0;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    res_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    gnt       <= '0;
                    res_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: doc/c1_share_arbiter.md
Name:
c1_share_arbiter

Overview:
- Round-robin arbiter and sequencer that time-shares one C1 logic-cell evaluation resource among NREQ requesters.
- Each requester presents a full 8-bit C1 configuration. The arbiter grants one requester, latches its configuration, evaluates the shared C1 cell, and returns a registered result tagged with the requester id.
- Sits between gate-level blocks built from C1 cells and a single shared C1 instance, so several small functions can be computed serially on one cell.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the result id; must equal clog2(NREQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  NREQ  level request, one bit per requester.
- cfg_flat  input  8*NREQ  packed configurations. Requester i occupies bits [8i+7:8i], ordered {s1,s0,sb,b1,b0,sa,a1,a0}.
- gnt  output  NREQ  one-hot grant; high for exactly one cycle per served request.
- res_valid  output  1  result strobe; high for one cycle.
- res_id  output  IDW  index of the requester the result belongs to.
- res_out  output  1  registered C1 result.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Shared cell function: out = (s0|s1) ? (sb ? b1 : b0) : (sa ? a1 : a0). It is evaluated only on the latched configuration register, never directly on cfg_flat.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - req == 0: stay in IDLE.
  - Otherwise select the winner k by round-robin: search starts at ptr, wrapping modulo NREQ.
  - At the clock edge: latch cfg_flat[8k+7:8k] into cfg_r, set id_r=k, set gnt=one-hot(k), set ptr=(k+1) mod NREQ, go to EVAL.
- EVAL:
  - gnt is high during this cycle.
  - At the clock edge: res_out <= C1(cfg_r), res_id <= id_r, res_valid <= 1, gnt <= 0, go to RESP.
- RESP:
  - res_valid is high during this cycle.
  - At the clock edge: res_valid <= 0, go to IDLE.
  - res_out and res_id hold their values until the next result.
- Latency and throughput:
  - req sampled at edge t gives gnt high in cycle t+1 and res_valid high in cycle t+2.
  - Throughput is one evaluation per 3 cycles.
- Handshake:
  - req is level-sensitive, and each grant serves exactly one evaluation.
  - A requester that holds req high is served again only after the round-robin pointer returns to it.
  - A requester drops req on seeing res_valid with res_id equal to its own index.
- Deasserting req after the grant does not cancel the operation; the result is still delivered.
- cfg_flat changes after the latch edge do not affect the in-flight result.
- A req change arriving during EVAL or RESP is only sampled in the next IDLE.
- A single active requester is served repeatedly, once every 3 cycles.
- Reset:
  - Asynchronous, and valid at any state including mid-operation.
  - Clears to state=IDLE, gnt=0, res_valid=0, res_out=0, res_id=0, busy=0, cfg_r=0, id_r=0, ptr=0 (requester 0 has first priority after reset).
  - An aborted operation produces no res_valid.
- Invariants: gnt has at most one bit set; gnt and res_valid are never high in the same cycle.

Test Plan:
- Reset, then req=4'b0001, cfg0=8'hC8 -> gnt=4'b0001 in cycle 2, res_valid=1 in cycle 3, res_id=0, res_out=1 (s0|s1=1, sb=0, so b0=1).
- req=4'b0010, cfg1=8'h01 -> res_out=1 (A path, sa=0, a0=1). Then cfg1=8'h00 -> res_out=0, res_id=1.
- req=4'b1111 held continuously from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart; res_id sequence 0, 1, 2, 3, 0.
- req=4'b0101 after serving id 0 -> next grant is id 2. Then with req=4'b0001 only -> next grant is id 0, after wrap-around.
- Grant requester 3 with cfg3=8'hC8, then change cfg3 to 8'h00 and drop req during EVAL -> res_out=1 and res_valid still asserted; no further grant occurs.
- Assert rst during EVAL -> all outputs go to 0 immediately with no res_valid. After release, req=4'b1000 is granted 1 cycle after sampling and ptr restarts at 0.
